seg_scan_ctl: RTL and testbench

//  Multiplexed N-digit 7-segment display controller for the syscall display path.

---
 rtl/seg_scan_ctl.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_ctl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctl.sv
// Multiplexed N-digit 7-segment controller: hex or decimal (sequential double-dabble)
// display with refresh prescaler, PWM brightness, decimal points and leading-zero blanking.
module seg_scan_ctl #(
  parameter int unsigned NDIG       = 8,
  parameter int unsigned CLK_DIV    = 1024,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [4*NDIG-1:0] i_val,
  input  logic              i_dec,
  input  logic              i_lz,
  input  logic [NDIG-1:0]   i_dp,
  input  logic [2:0]        i_bright,
  output logic              o_busy,
  output logic              o_ovf,
  output logic [NDIG-1:0]   o_ctl,
  output logic [7:0]        o_seg
);

  localparam int unsigned VW = 4 * NDIG;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = PW + 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW = $clog2(VW + 1);
  localparam logic [NDIG-1:0] CTL_OFF = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic [7:0]      SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   shown_q, shown_d;
  logic [NDIG-1:0] dp_q, dp_d;
  logic            lz_q, lz_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic [VW-1:0]   bin_q, bin_d;
  logic [VW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            covf_q, covf_d;
  logic [NDIG-1:0] pdp_q, pdp_d;
  logic            plz_q, plz_d;
  logic [NDIG-1:0] ctl_q, ctl_d;
  logic [7:0]      seg_q, seg_d;

  logic [VW-1:0]   adj_c;
  logic [NDIG-1:0] blank_c;
  logic [TW-1:0]   thr_c;
  logic [3:0]      nib_c;
  logic [7:0]      seg_hi_c;
  logic [NDIG-1:0] ctl_hi_c;
  logic            nz_c;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Refresh prescaler and digit index
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(CLK_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Double-dabble correction: +3 on every BCD digit >= 5 before shifting
  always_comb begin
    adj_c = bcd_q;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    shown_d = shown_q;
    dp_d    = dp_q;
    lz_d    = lz_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    covf_d  = covf_q;
    pdp_d   = pdp_q;
    plz_d   = plz_q;
    if (busy_q) begin
      // Final cycle swaps the whole converted result in at once
      if (cnt_q == CW'(VW)) begin
        shown_d = bcd_q;
        ovf_d   = covf_q;
        dp_d    = pdp_q;
        lz_d    = plz_q;
        busy_d  = 1'b0;
      end else begin
        bcd_d  = {adj_c[VW-2:0], bin_q[VW-1]};
        bin_d  = {bin_q[VW-2:0], 1'b0};
        covf_d = covf_q | adj_c[VW-1];
        cnt_d  = cnt_q + CW'(1);
      end
    end else if (i_load) begin
      if (i_dec) begin
        busy_d = 1'b1;
        bin_d  = i_val;
        bcd_d  = '0;
        cnt_d  = '0;
        covf_d = 1'b0;
        pdp_d  = i_dp;
        plz_d  = i_lz;
      end else begin
        shown_d = i_val;
        dp_d    = i_dp;
        lz_d    = i_lz;
        ovf_d   = 1'b0;
      end
    end
  end

  // Digit k blanks when it and every digit above it are zero (digit 0 never blanks)
  always_comb begin
    nz_c    = 1'b0;
    blank_c = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nz_c       = nz_c | (|shown_q[4*k +: 4]);
      blank_c[k] = lz_q && !nz_c && (k != 0);
    end
  end

  always_comb begin
    thr_c    = TW'((TW'(i_bright) + TW'(1)) * TW'(CLK_DIV / 8));
    nib_c    = shown_q[{idx_q, 2'b00} +: 4];
    seg_hi_c = ovf_q ? 8'h40 : blank_c[idx_q] ? 8'h00 : {dp_q[idx_q], glyph(nib_c)};
    ctl_hi_c = ({1'b0, presc_q} < thr_c) ? (NDIG'(1) << idx_q) : '0;
    ctl_d    = (ACTIVE_LOW != 0) ? ~ctl_hi_c : ctl_hi_c;
    seg_d    = (ACTIVE_LOW != 0) ? ~seg_hi_c : seg_hi_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      dp_q    <= '0;
      lz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      covf_q  <= 1'b0;
      pdp_q   <= '0;
      plz_q   <= 1'b0;
      ctl_q   <= CTL_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      dp_q    <= dp_d;
      lz_q    <= lz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      covf_q  <= covf_d;
      pdp_q   <= pdp_d;
      plz_q   <= plz_d;
      ctl_q   <= ctl_d;
      seg_q   <= seg_d;
    end
  end

  assign o_busy = busy_q;
  assign o_ovf  = ovf_q;
  assign o_ctl  = ctl_q;
  assign o_seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_ctl.sv
// Scoreboard bench for seg_scan_ctl: loads push the expected display frame, a monitor
// captures one full scan frame once the DUT is idle and compares it.
module tb_seg_scan_ctl;

  localparam int NDIG   = 8;
  localparam int CDIV   = 8;
  localparam int CDIV64 = 64;

  typedef struct packed {
    logic              ovf;
    logic [2:0]        br;
    logic [NDIG*8-1:0] segs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load, dec, lz;
  logic [31:0] val;
  logic [7:0]  dp;
  logic [2:0]  bright;
  logic        busy, ovf, busy64, ovf64;
  logic [7:0]  ctl, seg, ctl64, seg64;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seg_scan_ctl #(.NDIG(NDIG), .CLK_DIV(CDIV), .ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_val(val), .i_dec(dec), .i_lz(lz),
    .i_dp(dp), .i_bright(bright), .o_busy(busy), .o_ovf(ovf), .o_ctl(ctl), .o_seg(seg));

  seg_scan_ctl #(.NDIG(NDIG), .CLK_DIV(CDIV64), .ACTIVE_LOW(1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_val(val), .i_dec(dec), .i_lz(lz),
    .i_dp(dp), .i_bright(bright), .o_busy(busy64), .o_ovf(ovf64), .o_ctl(ctl64), .o_seg(seg64));

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask

  // Reference: digits by division/shift, overflow when the decimal value needs > NDIG digits
  function automatic exp_t model(input logic [31:0] v, input logic d, input logic l,
                                 input logic [7:0] p, input logic [2:0] br);
    exp_t            e;
    longint unsigned above, pw;
    int              dg;
    e.ovf  = 1'b0;
    e.br   = br;
    e.segs = '0;
    if (d && 64'(v) >= 64'd100_000_000) begin
      e.ovf = 1'b1;
      for (int k = 0; k < NDIG; k++) e.segs[8*k +: 8] = 8'h40;
      return e;
    end
    pw = 1;
    for (int k = 0; k < NDIG; k++) begin
      if (d) begin
        above = 64'(v) / pw;
        dg    = int'(above % 10);
        pw    = pw * 10;
      end else begin
        above = 64'(v) >> (4 * k);
        dg    = int'(above & 15);
      end
      if (l && k > 0 && above == 0) e.segs[8*k +: 8] = 8'h00;
      else e.segs[8*k +: 8] = glyph[dg] | (p[k] ? 8'h80 : 8'h00);
    end
    return e;
  endfunction

  // Monitor: once idle, skip one frame, then capture a full frame and compare
  initial begin : monitor
    exp_t       e;
    logic [7:0] obs [NDIG];
    int         cnt [NDIG];
    logic       ghost, incons;
    logic [7:0] act;
    int         n;
    forever begin
      @(negedge clk);
      if (q.size() != 0 && rst_n) begin
        e = q[0];
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        chk("busy timeout", 64'(busy), 64'(0));
        repeat (NDIG * CDIV) @(negedge clk);
        ghost = 1'b0; incons = 1'b0;
        for (int k = 0; k < NDIG; k++) begin obs[k] = 8'h00; cnt[k] = 0; end
        for (int c = 0; c < NDIG * CDIV; c++) begin
          @(negedge clk);
          act = ~ctl;
          if ($countones(act) > 1) ghost = 1'b1;
          for (int k = 0; k < NDIG; k++) begin
            if (act[k]) begin
              if (cnt[k] != 0 && obs[k] != ~seg) incons = 1'b1;
              obs[k] = ~seg;
              cnt[k]++;
            end
          end
        end
        chk("ovf flag", 64'(ovf), 64'(e.ovf));
        chk("one-hot ctl", 64'(ghost), 64'(0));
        chk("stable seg in slot", 64'(incons), 64'(0));
        for (int k = 0; k < NDIG; k++) begin
          chk($sformatf("digit%0d seg", k), 64'(obs[k]), 64'(e.segs[8*k +: 8]));
          chk($sformatf("digit%0d on-cycles", k), 64'(cnt[k]), 64'((int'(e.br) + 1) * CDIV / 8));
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    chk("scoreboard drain", 64'(q.size()), 64'(0));
  endtask

  task automatic do_load(input logic [31:0] v, input logic d, input logic l,
                         input logic [7:0] p, input logic [2:0] br, input int glitch);
    int n;
    @(negedge clk);
    bright = br; val = v; dec = d; lz = l; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    q.push_back(model(v, d, l, p, br));
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == glitch) begin val = 32'h11; dec = 1'($urandom_range(0, 1)); load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    chk("busy cycles", 64'(n), d ? 64'(4 * NDIG + 1) : 64'(0));
    drain();
  endtask

  task automatic pwm_check(input logic [2:0] br);
    int         act, run, maxrun;
    logic [7:0] prev;
    @(negedge clk);
    bright = br;
    repeat (3) @(negedge clk);
    act = 0; run = 0; maxrun = 0; prev = 8'hFF;
    for (int c = 0; c < NDIG * CDIV64; c++) begin
      @(negedge clk);
      if (ctl64 != 8'hFF) begin
        act++;
        run = (ctl64 == prev) ? run + 1 : 1;
      end else run = 0;
      if (run > maxrun) maxrun = run;
      prev = ctl64;
    end
    chk($sformatf("pwm total bright%0d", br), 64'(act), 64'(NDIG * (int'(br) + 1) * CDIV64 / 8));
    chk($sformatf("pwm run bright%0d", br), 64'(maxrun), 64'((int'(br) + 1) * CDIV64 / 8));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v;
    int          sel;
    rst_n = 1'b1; load = 1'b0; dec = 1'b0; lz = 1'b0; val = '0; dp = '0; bright = 3'd7;
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset ovf", 64'(ovf), 64'(0));
    chk("reset ctl", 64'(ctl), 64'h00FF);
    chk("reset seg", 64'(seg), 64'h00FF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.push_back(model(32'h0, 1'b0, 1'b0, 8'h00, bright));
    drain();

    do_load(32'h0000_00A5, 1'b0, 1'b1, 8'h00, 3'd7, 0);
    do_load(32'd12345678, 1'b1, 1'b0, 8'h00, 3'd7, 0);
    do_load(32'd100000000, 1'b1, 1'b0, 8'h00, 3'd5, 0);
    do_load(32'hDEAD_BEEF, 1'b0, 1'b0, 8'h21, 3'd7, 0);
    do_load(32'd87654321, 1'b1, 1'b1, 8'h04, 3'd2, 5);
    do_load(32'd99999999, 1'b1, 1'b0, 8'h00, 3'd7, 0);

    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 999));
        2:       v = 32'(99_999_990 + $urandom_range(0, 19));
        default: v = 32'($urandom_range(0, 99_999_999));
      endcase
      do_load(v, (sel == 2) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 3'($urandom), 0);
    end

    do_load(32'h0000_0042, 1'b0, 1'b0, 8'h00, 3'd7, 0);
    pwm_check(3'd0);
    pwm_check(3'd3);
    chk("dut64 busy", 64'(busy64), 64'(0));
    chk("dut64 ovf", 64'(ovf64), 64'(0));
    chk("dut64 seg inactive or driven", 64'(seg64 === 8'hxx), 64'(0));

    @(negedge clk);
    bright = 3'd7; val = 32'd55555555; dec = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy before reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid-reset busy", 64'(busy), 64'(0));
    chk("mid-reset ovf", 64'(ovf), 64'(0));
    chk("mid-reset ctl", 64'(ctl), 64'h00FF);
    chk("mid-reset seg", 64'(seg), 64'h00FF);
    chk("mid-reset ctl64", 64'(ctl64), 64'h00FF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.push_back(model(32'h0, 1'b0, 1'b0, 8'h00, bright));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
